// File: rtl/pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_sample_feeder
//  Purpose  : PCM sample FIFO feeding a 1-bit PWM DAC. The host pushes
//             16-bit signed samples. Each next_sample strobe pops one sample
//             into the playback register. pwm_out compares the oversample
//             phase against the sample's offset-binary duty value. The block
//             reports FIFO level and sticky overflow/underrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module pcm_sample_feeder #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          dac_clk,
    input  logic          next_sample,
    input  logic [8:0]    phase,
    input  logic          clr_flags,
    output logic [15:0]   sample_cur,
    output logic          pwm_out,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf
);

    localparam int            c_DEPTH      = 1 << AW;
    localparam logic [AW:0]   c_FULL_LEVEL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_ZERO_LEVEL = '0;
    localparam logic [8:0]    c_DUTY_MID   = 9'd256;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   mem_q [c_DEPTH];
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   level_q,    level_d;
    logic          full_q,     full_d;
    logic          empty_q,    empty_d;
    logic [15:0]   sample_q,   sample_d;
    logic [8:0]    duty_q,     duty_d;
    logic          pwm_q,      pwm_d;
    logic          ovf_q,      ovf_d;
    logic          unf_q,      unf_d;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic        w_pop_req;    // strobe on a non-empty FIFO
    logic        w_pop;        // pop actually performed (flush blocks it)
    logic        w_push;       // push actually performed
    logic        w_ovf_set;
    logic        w_unf_set;
    logic [15:0] w_head;

    assign w_head    = mem_q[rd_ptr_q];
    assign w_pop_req = next_sample & ~empty_q;
    assign w_pop     = w_pop_req & ~flush;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push    = wr_en & ~flush & (~full_q | w_pop_req);
    assign w_ovf_set = wr_en & full_q & ~w_pop_req;
    // No write-through: an empty FIFO underruns even if a push arrives now.
    assign w_unf_set = next_sample & empty_q;

    // Pointer, level and status next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                level_d = level_q + 1'b1;
            end else if (w_pop && !w_push) begin
                level_d = level_q - 1'b1;
            end
        end
        full_d  = (level_d == c_FULL_LEVEL);
        empty_d = (level_d == c_ZERO_LEVEL);
    end

    // Playback sample, duty, PWM and sticky flags next-state
    always_comb begin
        sample_d = sample_q;
        duty_d   = duty_q;
        pwm_d    = pwm_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (w_pop) begin
            sample_d = w_head;
            // Signed to offset binary: flip sign bit, keep top 9 bits.
            duty_d   = {~w_head[15], w_head[14:7]};
        end
        // Compare uses the duty in force before any same-cycle pop, so a
        // new sample only takes effect from the next PWM period.
        if (dac_clk) begin
            pwm_d = (phase < duty_q);
        end
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_flags) begin
            ovf_d = 1'b0;
        end
        if (w_unf_set) begin
            unf_d = 1'b1;
        end else if (clr_flags) begin
            unf_d = 1'b0;
        end
    end

    // Sample storage; contents need no reset because level gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Playback, PWM and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            duty_q   <= c_DUTY_MID;
            pwm_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sample_q <= sample_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign sample_cur = sample_q;
    assign pwm_out    = pwm_q;
    assign level      = level_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcm_sample_feeder
//  Purpose  : Self-checking bench for pcm_sample_feeder with a queue-based
//             reference model and directed plus randomized scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcm_sample_feeder;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = '0;
    logic          dac_clk = 1'b0;
    logic          next_sample = 1'b0;
    logic [8:0]    phase = '0;
    logic          clr_flags = 1'b0;
    logic [15:0]   sample_cur;
    logic          pwm_out;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    int total = 0;
    int bad   = 0;

    pcm_sample_feeder #(.AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .dac_clk     (dac_clk),
        .next_sample (next_sample),
        .phase       (phase),
        .clr_flags   (clr_flags),
        .sample_cur  (sample_cur),
        .pwm_out     (pwm_out),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of samples plus playback/flag state
    // ------------------------------------------------------------------
    logic [15:0] mq[$];
    logic [15:0] m_cur;
    int          m_duty;
    logic        m_pwm;
    logic        m_ovf;
    logic        m_unf;

    function automatic int duty_of(input logic [15:0] s);
        // Offset binary: map -32768..32767 to 0..65535, keep top 9 bits.
        return (int'($signed(s)) + 32768) / 128;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cur  = '0;
        m_duty = 256;
        m_pwm  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then clock
    // the DUT and settle 1 time unit past the edge.
    task automatic tick();
        int  sz;
        bit  can_pop, do_push, set_o, set_u;
        sz      = mq.size();
        can_pop = next_sample && (sz > 0);
        set_o   = wr_en && (sz == DEPTH) && !can_pop;
        set_u   = next_sample && (sz == 0);
        do_push = wr_en && !flush && ((sz < DEPTH) || can_pop);
        if (dac_clk) m_pwm = (int'(phase) < m_duty);
        if (flush) begin
            mq.delete();
        end else begin
            if (can_pop) begin
                m_cur  = mq.pop_front();
                m_duty = duty_of(m_cur);
            end
            if (do_push) mq.push_back(wr_data);
        end
        if (set_o) m_ovf = 1'b1; else if (clr_flags) m_ovf = 1'b0;
        if (set_u) m_unf = 1'b1; else if (clr_flags) m_unf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; wr_en = 1'b0; dac_clk = 1'b0;
        next_sample = 1'b0; clr_flags = 1'b0; phase = '0;
    endtask

    // One full PWM period: dac_clk every cycle, phase 0..511, optional
    // next_sample at phase 511. Returns the number of high pwm ticks.
    task automatic run_period(input bit strobe_at_end, output int highs);
        highs = 0;
        for (int p = 0; p < 512; p++) begin
            dac_clk     = 1'b1;
            phase       = 9'(p);
            next_sample = strobe_at_end && (p == 511);
            tick();
            if (pwm_out === 1'b1) highs++;
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int highs;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        total++; if (level !== '0)          begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)         begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (sample_cur !== 16'h0)  begin bad++; $display("FAIL reset_sample got=%h exp=0000", sample_cur); end
        total++; if (pwm_out !== 1'b0)      begin bad++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
        total++; if ({ovf, unf} !== 2'b00)  begin bad++; $display("FAIL reset_flags got=%b%b exp=00", ovf, unf); end
        run_period(1'b0, highs);
        total++; if (highs !== 256)         begin bad++; $display("FAIL reset_pwm_count got=%0d exp=256", highs); end
    endtask

    task automatic test_pwm_extremes();
        logic [15:0] vals [3];
        int          exp_cnt [4];
        int          highs;
        vals[0] = 16'h7FFF; vals[1] = 16'h8000; vals[2] = 16'h0000;
        exp_cnt[0] = 256; exp_cnt[1] = 511; exp_cnt[2] = 0; exp_cnt[3] = 256;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = vals[i];
            tick();
        end
        wr_en = 1'b0;
        total++; if (level !== 5'd3) begin bad++; $display("FAIL ext_level3 got=%0d exp=3", level); end
        for (int i = 0; i < 4; i++) begin
            run_period(i < 3, highs);
            total++; if (highs !== exp_cnt[i]) begin bad++; $display("FAIL ext_count[%0d] got=%0d exp=%0d", i, highs, exp_cnt[i]); end
            if (i < 3) begin
                total++; if (sample_cur !== vals[i]) begin bad++; $display("FAIL ext_sample[%0d] got=%h exp=%h", i, sample_cur, vals[i]); end
            end
        end
        total++; if (level !== '0 || empty !== 1'b1) begin bad++; $display("FAIL ext_level_end got=%0d/%b exp=0/1", level, empty); end
        total++; if (unf !== 1'b0) begin bad++; $display("FAIL ext_unf got=%b exp=0", unf); end
    endtask

    task automatic test_overflow();
        logic [15:0] d [DEPTH+1];
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            d[i]    = 16'($urandom);
            wr_en   = 1'b1;
            wr_data = d[i];
            tick();
            if (i == DEPTH - 1) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
            end
        end
        wr_en = 1'b0;
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        total++; if (full !== 1'b1)   begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
        total++; if (ovf !== 1'b1)    begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            next_sample = 1'b1;
            tick();
            total++; if (sample_cur !== d[i]) begin bad++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, sample_cur, d[i]); end
        end
        next_sample = 1'b0;
        total++; if (level !== '0 || empty !== 1'b1) begin bad++; $display("FAIL ovf_drain got=%0d/%b exp=0/1", level, empty); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] e [DEPTH];
        logic [15:0] x;
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            e[i] = 16'($urandom); wr_en = 1'b1; wr_data = e[i];
            tick();
        end
        x = 16'($urandom);
        wr_data = x; next_sample = 1'b1;
        tick();
        wr_en = 1'b0; next_sample = 1'b0;
        total++; if (level !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fpp_level got=%0d/%b exp=16/1", level, full); end
        total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL fpp_ovf got=%b exp=0", ovf); end
        total++; if (sample_cur !== e[0]) begin bad++; $display("FAIL fpp_head got=%h exp=%h", sample_cur, e[0]); end
        for (int i = 1; i <= DEPTH; i++) begin
            next_sample = 1'b1; tick();
        end
        next_sample = 1'b0;
        total++; if (sample_cur !== x) begin bad++; $display("FAIL fpp_tail got=%h exp=%h", sample_cur, x); end
    endtask

    task automatic test_underrun();
        logic [15:0] prev, y;
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        prev = sample_cur;
        y = 16'($urandom);
        wr_en = 1'b1; wr_data = y; next_sample = 1'b1;
        tick();
        wr_en = 1'b0; next_sample = 1'b0;
        total++; if (unf !== 1'b1)        begin bad++; $display("FAIL unf_set got=%b exp=1", unf); end
        total++; if (sample_cur !== prev) begin bad++; $display("FAIL unf_hold got=%h exp=%h", sample_cur, prev); end
        total++; if (level !== 5'd1)      begin bad++; $display("FAIL unf_level got=%0d exp=1", level); end
        next_sample = 1'b1; tick();
        total++; if (sample_cur !== y)    begin bad++; $display("FAIL unf_stored got=%h exp=%h", sample_cur, y); end
        clr_flags = 1'b1; tick();
        clr_flags = 1'b0; next_sample = 1'b0;
        total++; if (unf !== 1'b1)        begin bad++; $display("FAIL unf_setwins got=%b exp=1", unf); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        total++; if (unf !== 1'b0)        begin bad++; $display("FAIL unf_clear got=%b exp=0", unf); end
    endtask

    task automatic test_async_reset_flush();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'($urandom); tick();
        end
        wr_en = 1'b0;
        total++; if (level !== 5'd5) begin bad++; $display("FAIL ar_pre_level got=%0d exp=5", level); end
        #2 rst = 1'b1;
        #1;
        total++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0)
            begin bad++; $display("FAIL ar_level got=%0d/%b/%b exp=0/1/0", level, empty, full); end
        total++; if (sample_cur !== 16'h0 || pwm_out !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0)
            begin bad++; $display("FAIL ar_outputs got=%h/%b/%b/%b exp=0000/0/0/0", sample_cur, pwm_out, ovf, unf); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'($urandom); tick();
        end
        flush = 1'b1; tick();
        flush = 1'b0; wr_en = 1'b0;
        total++; if (level !== '0 || empty !== 1'b1) begin bad++; $display("FAIL flush_level got=%0d/%b exp=0/1", level, empty); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_data     = 16'($urandom);
            next_sample = ($urandom_range(0, 3) == 0);
            dac_clk     = ($urandom_range(0, 1) == 1);
            phase       = 9'($urandom);
            clr_flags   = ($urandom_range(0, 15) == 0);
            flush       = ($urandom_range(0, 31) == 0);
            tick();
            total++;
            if (level !== 5'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                bad++; $display("FAIL rnd_level[%0d] got=%0d/%b/%b exp=%0d", n, level, full, empty, mq.size());
            end
            total++;
            if (sample_cur !== m_cur || pwm_out !== m_pwm) begin
                bad++; $display("FAIL rnd_play[%0d] got=%h/%b exp=%h/%b", n, sample_cur, pwm_out, m_cur, m_pwm);
            end
            total++;
            if (ovf !== m_ovf || unf !== m_unf) begin
                bad++; $display("FAIL rnd_flags[%0d] got=%b%b exp=%b%b", n, ovf, unf, m_ovf, m_unf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pwm_extremes();
        test_overflow();
        test_full_push_pop();
        test_underrun();
        test_async_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
